// File: rtl/hb_step_decoder_if.sv
// Bundles the observed H-bridge lines, position clear and decoded motion outputs.
// master drives hb_in/clr_pos and observes; slave is the decoder side.
interface hb_step_decoder_if #(
  parameter int POS_WIDTH = 32
);
  logic [3:0]           hb_in;
  logic                 clr_pos;
  logic [POS_WIDTH-1:0] position;
  logic                 step_pulse;
  logic                 step_dir;
  logic                 moving;
  logic                 err_illegal;
  logic [7:0]           err_count;
  logic [1:0]           phase_idx;
  logic                 stall;

  modport master (
    output hb_in, clr_pos,
    input  position, step_pulse, step_dir, moving, err_illegal, err_count, phase_idx, stall
  );

  modport slave (
    input  hb_in, clr_pos,
    output position, step_pulse, step_dir, moving, err_illegal, err_count, phase_idx, stall
  );
endinterface

// File: rtl/hb_step_decoder.sv
// Reconstructs stepper motion (position, step, direction, faults) from observed H-bridge phase lines.
// Optional stall timeout in RUN is built only when HB_STALL_TIMEOUT_EN is defined.
module hb_step_decoder #(
  parameter int SYNC_STAGES  = 2,
  parameter int POS_WIDTH    = 32,
  parameter int STALL_CYCLES = 100000
) (
  input logic             clk,
  input logic             PRESET,
  hb_step_decoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  if (SYNC_STAGES < 2 || STALL_CYCLES < 2) begin : g_bad_param
    $error("hb_step_decoder: SYNC_STAGES and STALL_CYCLES must be at least 2");
  end

  // Packed shift chain: newest sample enters at the low nibble.
  logic [4*SYNC_STAGES-1:0] sync_reg;
  logic [3:0]               s;
  logic [3:0]               prev_reg;

  always_ff @(posedge clk or posedge PRESET) begin
    if (PRESET) begin
      sync_reg <= '0;
      prev_reg <= 4'b0000;
    end else begin
      sync_reg <= {sync_reg[4*SYNC_STAGES-5:0], bus.hb_in};
      prev_reg <= s;
    end
  end

  assign s = sync_reg[4*SYNC_STAGES-1 -: 4];

  function automatic logic [2:0] decode(input logic [3:0] code);
    case (code)
      4'b1001: decode = 3'b100;
      4'b0101: decode = 3'b101;
      4'b0110: decode = 3'b110;
      4'b1010: decode = 3'b111;
      default: decode = 3'b000;
    endcase
  endfunction

  logic       s_valid;
  logic [1:0] s_idx;
  logic [1:0] idx_fwd;
  logic [1:0] idx_rev;
  logic       s_changed;

  assign {s_valid, s_idx} = decode(s);
  assign idx_fwd   = bus.phase_idx + 2'd1;
  assign idx_rev   = bus.phase_idx - 2'd1;
  assign s_changed = (s != prev_reg);

  state_t               state_reg, state_next;
  logic [POS_WIDTH-1:0] position_reg, position_next;
  logic                 step_pulse_reg, step_pulse_next;
  logic                 step_dir_reg, step_dir_next;
  logic                 err_illegal_reg, err_illegal_next;
  logic [7:0]           err_count_reg, err_count_next;
  logic [1:0]           phase_idx_reg, phase_idx_next;
  logic                 illegal;
  logic                 run_entry;
  logic                 stall_hit;

`ifdef HB_STALL_TIMEOUT_EN
  localparam int CW = (STALL_CYCLES > 2) ? $clog2(STALL_CYCLES) : 1;
  logic [CW-1:0] stall_cnt_reg, stall_cnt_next;
  logic          stall_reg;

  assign stall_hit = (state_reg == RUN) && !s_changed &&
                     (stall_cnt_reg == CW'(STALL_CYCLES - 1));

  always_comb begin
    stall_cnt_next = '0;
    if (state_reg == RUN && !s_changed && !stall_hit)
      stall_cnt_next = stall_cnt_reg + CW'(1);
  end

  always_ff @(posedge clk or posedge PRESET) begin
    if (PRESET) begin
      stall_cnt_reg <= '0;
      stall_reg     <= 1'b0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
      stall_reg     <= stall_hit;
    end
  end

  assign bus.stall = stall_reg;
`else
  assign stall_hit = 1'b0;
  assign bus.stall = 1'b0;
`endif

  always_comb begin
    state_next       = state_reg;
    position_next    = position_reg;
    step_pulse_next  = 1'b0;
    step_dir_next    = step_dir_reg;
    err_illegal_next = 1'b0;
    err_count_next   = err_count_reg;
    phase_idx_next   = phase_idx_reg;
    illegal          = 1'b0;
    run_entry        = 1'b0;

    case (state_reg)
      IDLE: begin
        // Entry needs a change so a stalled-out static phase does not bounce back into RUN.
        if (s_valid && s_changed) begin
          run_entry      = 1'b1;
          state_next     = RUN;
          phase_idx_next = s_idx;
        end else if (!s_valid && s != 4'b0000) begin
          illegal = 1'b1;
        end
      end
      RUN: begin
        if (s_changed) begin
          if (s == 4'b0000) begin
            state_next = IDLE;
          end else if (!s_valid) begin
            illegal = 1'b1;
          end else if (s_idx == idx_fwd) begin
            position_next   = position_reg + POS_WIDTH'(1);
            step_pulse_next = 1'b1;
            step_dir_next   = 1'b1;
            phase_idx_next  = s_idx;
          end else if (s_idx == idx_rev) begin
            position_next   = position_reg - POS_WIDTH'(1);
            step_pulse_next = 1'b1;
            step_dir_next   = 1'b0;
            phase_idx_next  = s_idx;
          end else begin
            illegal = 1'b1;
          end
        end else if (stall_hit) begin
          state_next = IDLE;
        end
      end
      FAULT: begin
        if (s == 4'b0000)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (illegal) begin
      err_illegal_next = 1'b1;
      state_next       = FAULT;
      if (err_count_reg != 8'hFF)
        err_count_next = err_count_reg + 8'd1;
    end

    if (bus.clr_pos)
      position_next = '0;
  end

  always_ff @(posedge clk or posedge PRESET) begin
    if (PRESET) begin
      state_reg       <= IDLE;
      position_reg    <= '0;
      step_pulse_reg  <= 1'b0;
      step_dir_reg    <= 1'b0;
      err_illegal_reg <= 1'b0;
      err_count_reg   <= 8'd0;
      phase_idx_reg   <= 2'd0;
    end else begin
      state_reg       <= state_next;
      position_reg    <= position_next;
      step_pulse_reg  <= step_pulse_next;
      step_dir_reg    <= step_dir_next;
      err_illegal_reg <= err_illegal_next;
      err_count_reg   <= err_count_next;
      phase_idx_reg   <= phase_idx_next;
    end
  end

  assign bus.position    = position_reg;
  assign bus.step_pulse  = step_pulse_reg;
  assign bus.step_dir    = step_dir_reg;
  assign bus.moving      = (state_reg == RUN);
  assign bus.err_illegal = err_illegal_reg;
  assign bus.err_count   = err_count_reg;
  assign bus.phase_idx   = phase_idx_reg;

endmodule
